// File: rtl/im_fetch_pkg.sv
// Shared state encoding and sizing defaults for the IM fetch controller.
// Optional build macro IM_FETCH_PERF_EN (stall counter) is handled in im_fetch_ctrl.
`ifndef INS_RAM_DEPTH
`define INS_RAM_DEPTH 256
`endif
`ifndef INS_RAM_DATA_WIDTH
`define INS_RAM_DATA_WIDTH 32
`endif
`ifndef INS_RAM_NUM_PIPE
`define INS_RAM_NUM_PIPE 1
`endif

package im_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } im_fetch_state_t;

    // Two spare entries beyond the read latency keep issue going at full rate.
    function automatic int fifo_depth_default(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/im_fetch_fifo.sv
// First-word-fall-through FIFO with occupancy count; depth need not be a power of two.
module im_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic          empty,
    output logic          full,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign head   = mem[rp];
    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)   wp <= nxt(wp);
            if (do_pop) rp <= nxt(rp);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Streams an instruction range from the IM to the decoder with credit-based prefetch.
// Define IM_FETCH_PERF_EN to add the stall_cnt output.
`ifndef INS_RAM_DEPTH
`define INS_RAM_DEPTH 256
`endif
`ifndef INS_RAM_DATA_WIDTH
`define INS_RAM_DATA_WIDTH 32
`endif
`ifndef INS_RAM_NUM_PIPE
`define INS_RAM_NUM_PIPE 1
`endif

module im_fetch_ctrl
    import im_fetch_pkg::*;
#(
    parameter int ADDR_W     = $clog2(`INS_RAM_DEPTH),
    parameter int DATA_W     = `INS_RAM_DATA_WIDTH,
    parameter int RD_LAT     = `INS_RAM_NUM_PIPE + 1,
    parameter int FIFO_DEPTH = fifo_depth_default(RD_LAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   n_ins,
    output logic              busy,
    output logic              done,
`ifdef IM_FETCH_PERF_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_data,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic              host_wr_err,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [DATA_W-1:0] im_din,
    output logic              im_rd_en,
    output logic [ADDR_W-1:0] im_rd_addr,
    input  logic [DATA_W-1:0] im_dout
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    im_fetch_state_t   state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   recv_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [FW-1:0]     in_flight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic [DATA_W-1:0] fifo_head;
    logic              can_issue;
    logic              pop;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + FW'(vld_pipe[i]);
    end

    // Credits: slots not yet claimed by buffered or in-flight words.
    assign can_issue  = (FW'(fifo_count) + in_flight) < FW'(FIFO_DEPTH);
    assign busy       = (state != IDLE);
    assign im_rd_en   = (state == FETCH) && (issue_cnt != '0) && can_issue;
    assign im_rd_addr = rd_ptr;
    assign im_wr_en   = host_wr_en && !busy;
    assign im_wr_addr = host_wr_addr;
    assign im_din     = host_din;
    assign fifo_push  = vld_pipe[RD_LAT-1];
    assign ins_valid  = !fifo_empty;
    assign ins_data   = fifo_empty ? '0 : fifo_head;
    assign pop        = ins_valid && ins_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            vld_pipe    <= '0;
            done        <= 1'b0;
            host_wr_err <= 1'b0;
        end else begin
            done        <= 1'b0;
            host_wr_err <= host_wr_en && busy;
            vld_pipe[0] <= im_rd_en;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (pop) recv_cnt <= recv_cnt - 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_ins != '0) begin
                            state     <= FETCH;
                            rd_ptr    <= start_addr;
                            issue_cnt <= n_ins;
                            recv_cnt  <= n_ins;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (im_rd_en) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        issue_cnt <= issue_cnt - 1'b1;
                        if (issue_cnt == 1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The final handshake is the only thing left to wait for.
                    if (pop && recv_cnt == 1) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IM_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (start && !busy)
            stall_cnt <= '0;
        else if (busy && ins_valid && !ins_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

    im_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (im_dout),
        .pop   (pop),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (fifo_head),
        .count (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !pop));

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl with an IM RAM model and a reference memory image.
`ifndef INS_RAM_DEPTH
`define INS_RAM_DEPTH 256
`endif
`ifndef INS_RAM_DATA_WIDTH
`define INS_RAM_DATA_WIDTH 32
`endif
`ifndef INS_RAM_NUM_PIPE
`define INS_RAM_NUM_PIPE 1
`endif

module tb_im_fetch_ctrl;
    localparam int DEPTH      = `INS_RAM_DEPTH;
    localparam int AW         = $clog2(DEPTH);
    localparam int DW         = `INS_RAM_DATA_WIDTH;
    localparam int RD_LAT     = `INS_RAM_NUM_PIPE + 1;
    localparam int FIFO_DEPTH = RD_LAT + 2;

    logic          clk, rst, start, busy, done, ins_valid, ins_ready;
    logic [AW-1:0] start_addr, host_wr_addr, im_wr_addr, im_rd_addr;
    logic [AW:0]   n_ins;
    logic [DW-1:0] ins_data, host_din, im_din, im_dout;
    logic          host_wr_en, host_wr_err, im_wr_en, im_rd_en;
`ifdef IM_FETCH_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    im_fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .n_ins(n_ins),
        .busy(busy), .done(done),
`ifdef IM_FETCH_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_din(host_din),
        .host_wr_err(host_wr_err), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
        .im_din(im_din), .im_rd_en(im_rd_en), .im_rd_addr(im_rd_addr), .im_dout(im_dout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // IM RAM model: fixed read latency, old data on read-during-write.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        if (im_wr_en) ram[im_wr_addr] <= im_din;
        rpipe[0] <= ram[im_rd_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign im_dout = rpipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] data_q [$];
    logic [AW-1:0] addr_q [$];
    int  start_cyc, last_hs, hs_cnt, outstanding = 0, done_due = -1;
    bit  chk_lat = 0, first_seen = 0, got_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every read issue, handshake and done pulse against the model.
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hs = ins_valid && ins_ready;
                if (im_rd_en) begin
                    if (addr_q.size() == 0) check("rd_unexpected", 1, 0);
                    else check("rd_addr", im_rd_addr, addr_q.pop_front());
                    check("credit", outstanding < FIFO_DEPTH, 1);
                end
                if (ins_valid && chk_lat && !first_seen) begin
                    check("first_valid_lat", cyc - start_cyc, RD_LAT + 1);
                    first_seen = 1;
                end
                if (hs) begin
                    if (data_q.size() == 0) check("data_unexpected", 1, 0);
                    else begin
                        check("data", ins_data, data_q.pop_front());
                        if (data_q.size() == 0) done_due = cyc + 1;
                    end
                    if (chk_lat && hs_cnt > 0) check("contiguous", cyc - last_hs, 1);
                    last_hs = cyc;
                    hs_cnt++;
                end
                if (done || cyc == done_due) check("done", done, cyc == done_due);
                if (done) got_done = 1;
                outstanding += int'(im_rd_en) - int'(hs);
            end
        end
    end

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic host_write(input int a, input logic [DW-1:0] d, input bit chk);
        host_wr_en = 1; host_wr_addr = a[AW-1:0]; host_din = d;
        ref_mem[a] = d;
        if (chk) begin
            @(negedge clk);
            check("wr_idle_en", im_wr_en, 1);
            check("wr_idle_addr", im_wr_addr, a[AW-1:0]);
            check("wr_idle_din", im_din, d);
        end
        @(posedge clk); #1;
        host_wr_en = 0;
        if (chk) begin
            @(negedge clk);
            check("wr_idle_noerr", host_wr_err, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic launch(input int a, input int n, input int mode, input bit lat);
        for (int i = 0; i < n; i++) begin
            addr_q.push_back(AW'((a + i) % DEPTH));
            data_q.push_back(ref_mem[(a + i) % DEPTH]);
        end
        chk_lat = lat; first_seen = 0; hs_cnt = 0; got_done = 0;
        start = 1; start_addr = a[AW-1:0]; n_ins = n[AW:0]; ins_ready = rdy(mode, 0);
        @(posedge clk); #1;
        start = 0;
        start_cyc = cyc;
        if (n == 0) done_due = cyc;
    endtask

    task automatic run_job(input int a, input int n, input int mode, input bit lat,
                           input int wr_at, input int wa, input logic [DW-1:0] wd);
        int k = 1;
        launch(a, n, mode, lat);
        while (!got_done && k < 3000) begin
            ins_ready = rdy(mode, k);
            if (k == wr_at) begin
                host_wr_en = 1; host_wr_addr = wa[AW-1:0]; host_din = wd;
            end
            @(negedge clk);
            if (k == wr_at) check("wr_blocked", im_wr_en, 0);
            if (wr_at > 0 && k == wr_at + 1) check("wr_err", host_wr_err, 1);
            if (wr_at > 0 && k == wr_at + 2) check("wr_err_pulse", host_wr_err, 0);
            @(posedge clk); #1;
            host_wr_en = 0;
            k++;
        end
        if (!got_done) check("job_timeout", 0, 1);
        chk_lat = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, ins_valid, 0);
        check({tag, "_data"}, ins_data, 0);
        check({tag, "_rd_en"}, im_rd_en, 0);
        check({tag, "_rd_addr"}, im_rd_addr, 0);
        check({tag, "_wr_err"}, host_wr_err, 0);
        check({tag, "_wr_en"}, im_wr_en, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst = 1; start = 0; start_addr = '0; n_ins = '0; ins_ready = 0;
        host_wr_en = 0; host_wr_addr = '0; host_din = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;

        for (int a = 0; a < DEPTH; a++) host_write(a, (a < 16) ? DW'(a) : DW'($urandom), 0);

        // Sequential stream, ready held high: latency, contiguity, done timing.
        run_job(0, 16, 0, 1, -1, 0, '0);
        // Backpressure pattern 1-0-0-1.
        run_job(100, 40, 1, 0, -1, 0, '0);
        // Address wrap at the top of the IM.
        run_job(DEPTH - 3, 6, 0, 0, -1, 0, '0);

        // Zero-length fetch.
        launch(5, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            check("n0_busy", busy, 0);
            @(posedge clk); #1;
        end
        check("n0_done_seen", got_done, 1);

        // Host write dropped while busy, then accepted when idle and read back.
        run_job(10, 20, 0, 0, 3, 50, 32'hCAFE0050);
        host_write(50, 32'hCAFE0050, 1);
        run_job(50, 1, 0, 0, -1, 0, '0);

        repeat (4) run_job($urandom_range(0, DEPTH - 1), $urandom_range(1, 30), 2, 0, -1, 0, '0);

        // Reset in the middle of a fetch.
        launch(180, 20, 0, 0);
        k = 0;
        while (hs_cnt < 5 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_progress", hs_cnt >= 5, 1);
        rst = 1; ins_ready = 0;
        @(posedge clk); #1;
        rst = 0;
        data_q.delete(); addr_q.delete();
        outstanding = 0; done_due = -1; got_done = 0;
        @(negedge clk);
        check_quiet("abort");
        ins_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", got_done, 0);
        run_job(200, 3, 0, 0, -1, 0, '0);
        check("abort_leftover", data_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
